ultrasonic_scan_ctrl: RTL and testbench

ULTRASONIC_SCAN_CTRL -- requirements
Module: ultrasonic_scan_ctrl

---
 rtl/sr04_pkg.sv | 19 +
 rtl/us_tick_gen.sv | 34 +++
 rtl/ultrasonic_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ultrasonic_scan_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr04_pkg.sv
// Shared constants for the HC-SR04 scan controller: FSM encoding and
// distance-field sentinels.
package sr04_pkg;

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StTrig     = 3'd1;
   localparam logic [2:0] StWaitRise = 3'd2;
   localparam logic [2:0] StMeasure  = 3'd3;
   localparam logic [2:0] StGap      = 3'd4;

   localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
   localparam logic [15:0] DIST_SAT     = 16'hFFFE;

   // Keeps a real measurement from ever aliasing the timeout code.
   function automatic logic [15:0] sat_dist(input logic [15:0] width);
      return (width >= DIST_SAT) ? DIST_SAT : width;
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_MHZ clocks, with a
// synchronous restart so the first tick lands CLK_MHZ cycles after restart.
module us_tick_gen #(
   parameter int unsigned CLK_MHZ = 50
) (
   input  logic Clk,
   input  logic Rst,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned CntW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_MHZ - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin HC-SR04 scanner: fixed-length slot per sensor, trigger pulse,
// echo-width measurement in microseconds, per-sensor result registers.
module ultrasonic_scan_ctrl
   import sr04_pkg::*;
#(
   parameter int unsigned CLK_MHZ       = 50,
   parameter int unsigned N_SENS        = 3,
   parameter int unsigned TRIG_US       = 10,
   parameter int unsigned RISE_LIMIT_US = 2000,
   parameter int unsigned ECHO_LIMIT_US = 38000,
   parameter int unsigned SLOT_US       = 60000
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 enable,
   input  logic [15:0]          thresh_us,
   input  logic [N_SENS-1:0]    echo,
   output logic [N_SENS-1:0]    trig,
   output logic [16*N_SENS-1:0] dist_us,
   output logic [N_SENS-1:0]    result_vld,
   output logic [N_SENS-1:0]    timeout,
   output logic [N_SENS-1:0]    obstacle,
   output logic                 busy,
   output logic [1:0]           cur_sel
);

   localparam int unsigned SlotW = $clog2(SLOT_US + 1);
   localparam logic [SlotW-1:0] TrigLast = SlotW'(TRIG_US - 1);
   localparam logic [SlotW-1:0] RiseLim  = SlotW'(RISE_LIMIT_US);
   localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_US - 1);
   localparam logic [15:0]      EchoLim  = 16'(ECHO_LIMIT_US);
   localparam logic [1:0]       SelLast  = 2'(N_SENS - 1);

   logic [2:0]              state_q, state_d;
   logic [1:0]              sel_q, sel_d;
   logic [SlotW-1:0]        slot_q, slot_d;
   logic [15:0]             width_q, width_d;
   logic [N_SENS-1:0]       echo_m_q, echo_s_q, echo_p_q;
   logic [N_SENS-1:0][15:0] dist_q, dist_d;
   logic [N_SENS-1:0]       vld_q, vld_d;
   logic [N_SENS-1:0]       tout_q, tout_d;
   logic [N_SENS-1:0]       obst_q, obst_d;

   logic tick, restart, rec_ok, rec_to;
   logic echo_cur, echo_rise;

   us_tick_gen #(
      .CLK_MHZ (CLK_MHZ)
   ) u_tick (
      .Clk       (Clk),
      .Rst       (Rst),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Edge history register makes a level already high at TRIG entry look flat.
   assign echo_cur  = echo_s_q[sel_q];
   assign echo_rise = echo_s_q[sel_q] & ~echo_p_q[sel_q];

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      slot_d  = tick ? slot_q + 1'b1 : slot_q;
      width_d = width_q;
      restart = 1'b0;
      rec_ok  = 1'b0;
      rec_to  = 1'b0;
      case (state_q)
         StIdle: begin
            slot_d = '0;
            if (enable) begin
               restart = 1'b1;
               state_d = StTrig;
            end
         end
         StTrig: begin
            if (tick && slot_q == TrigLast) state_d = StWaitRise;
         end
         StWaitRise: begin
            if (slot_q >= RiseLim) begin
               rec_to  = 1'b1;
               state_d = StGap;
            end else if (echo_rise) begin
               width_d = '0;
               state_d = StMeasure;
            end
         end
         StMeasure: begin
            if (tick) width_d = width_q + 1'b1;
            if (width_q >= EchoLim) begin
               rec_to  = 1'b1;
               state_d = StGap;
            end else if (!echo_cur) begin
               rec_ok  = 1'b1;
               state_d = StGap;
            end
         end
         StGap: begin
            // Exit on the tick that completes the slot so trig period is exact.
            if (tick && slot_q >= SlotLast) begin
               sel_d  = (sel_q >= SelLast) ? 2'd0 : sel_q + 1'b1;
               slot_d = '0;
               if (enable) begin
                  restart = 1'b1;
                  state_d = StTrig;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dist_d = dist_q;
      tout_d = tout_q;
      obst_d = obst_q;
      vld_d  = '0;
      if (rec_ok) begin
         dist_d[sel_q] = sat_dist(width_q);
         tout_d[sel_q] = 1'b0;
         obst_d[sel_q] = (width_q < thresh_us);
         vld_d[sel_q]  = 1'b1;
      end else if (rec_to) begin
         dist_d[sel_q] = DIST_TIMEOUT;
         tout_d[sel_q] = 1'b1;
         obst_d[sel_q] = 1'b0;
         vld_d[sel_q]  = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         slot_q   <= '0;
         width_q  <= '0;
         echo_m_q <= '0;
         echo_s_q <= '0;
         echo_p_q <= '0;
         dist_q   <= '0;
         vld_q    <= '0;
         tout_q   <= '0;
         obst_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         slot_q   <= slot_d;
         width_q  <= width_d;
         echo_m_q <= echo;
         echo_s_q <= echo_m_q;
         echo_p_q <= echo_s_q;
         dist_q   <= dist_d;
         vld_q    <= vld_d;
         tout_q   <= tout_d;
         obst_q   <= obst_d;
      end
   end

   always_comb begin
      trig = '0;
      if (state_q == StTrig) trig[sel_q] = 1'b1;
   end

   assign dist_us    = dist_q;
   assign result_vld = vld_q;
   assign timeout    = tout_q;
   assign obstacle   = obst_q;
   assign busy       = (state_q != StIdle);
   assign cur_sel    = sel_q;

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Randomized slot-level bench for ultrasonic_scan_ctrl, using scaled-down
// timing so a full scan round takes a few hundred cycles.
module tb_ultrasonic_scan_ctrl;

   localparam int CLK_MHZ = 2;
   localparam int N_SENS  = 3;
   localparam int TRIG_US = 3;
   localparam int RISE_US = 20;
   localparam int ECHO_US = 60;
   localparam int SLOT_US = 120;
   localparam int SLOT_C  = SLOT_US * CLK_MHZ;
   localparam int TRIG_C  = TRIG_US * CLK_MHZ;
   localparam int NSLOT   = 20;

   localparam int KNorm  = 0;
   localparam int KNone  = 1;
   localparam int KStale = 2;
   localparam int KLong  = 3;

   logic                 Clk = 1'b0;
   logic                 Rst = 1'b1;
   logic                 enable = 1'b0;
   logic [15:0]          thresh_us = '0;
   logic [N_SENS-1:0]    echo = '0;
   logic [N_SENS-1:0]    trig;
   logic [16*N_SENS-1:0] dist_us;
   logic [N_SENS-1:0]    result_vld;
   logic [N_SENS-1:0]    timeout;
   logic [N_SENS-1:0]    obstacle;
   logic                 busy;
   logic [1:0]           cur_sel;

   int n_vec = 0;
   int n_err = 0;
   int exp_sel = 0;

   int kinds[NSLOT];
   int ds[NSLOT];
   int ws[NSLOT];
   int ths[NSLOT];

   always #5 Clk = ~Clk;

   ultrasonic_scan_ctrl #(
      .CLK_MHZ       (CLK_MHZ),
      .N_SENS        (N_SENS),
      .TRIG_US       (TRIG_US),
      .RISE_LIMIT_US (RISE_US),
      .ECHO_LIMIT_US (ECHO_US),
      .SLOT_US       (SLOT_US)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .enable     (enable),
      .thresh_us  (thresh_us),
      .echo       (echo),
      .trig       (trig),
      .dist_us    (dist_us),
      .result_vld (result_vld),
      .timeout    (timeout),
      .obstacle   (obstacle),
      .busy       (busy),
      .cur_sel    (cur_sel)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [N_SENS-1:0] oh(input int s);
      logic [N_SENS-1:0] r;
      r = '0;
      r[s] = 1'b1;
      return r;
   endfunction

   function automatic logic [15:0] dist_of(input int s);
      return dist_us[16*s +: 16];
   endfunction

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_trig"}, trig, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_sel"}, cur_sel, 0);
      chk({pfx, "_dist"}, dist_us, 0);
      chk({pfx, "_vld"}, result_vld, 0);
      chk({pfx, "_tout"}, timeout, 0);
      chk({pfx, "_obst"}, obstacle, 0);
   endtask

   // One sensor slot as seen from its trigger rise. Sensor behaviour per kind:
   // normal/long echo rises d us after trig and stays high w us; none never
   // rises; stale is already high before trig and falls after the rise limit.
   task automatic run_slot(input int kind, input int d, input int w, input int th,
                           input bit pre_next, input int drop_k, input int rst_k);
      int n, hi, bad, vcnt, vbad, vk, thr_k, nxt;
      logic e_on;
      logic [15:0] got;
      nxt = (exp_sel + 1) % N_SENS;
      n = 0;
      while (trig == '0 && n < 3 * SLOT_C) begin
         step();
         n++;
      end
      if (trig == '0) begin
         chk("trig_seen", 0, 1);
         return;
      end
      chk($sformatf("trig_sel%0d", exp_sel), trig, oh(exp_sel));
      chk("cur_sel", cur_sel, exp_sel);
      chk("busy", busy, 1);
      thr_k = (kind == KNorm) ? (d + w - 2) * CLK_MHZ : 0;
      hi = 0; bad = 0; vcnt = 0; vbad = 0; vk = -1;
      for (int k = 0; k < SLOT_C; k++) begin
         if (trig != '0) hi++;
         if ((trig & ~oh(exp_sel)) != '0) bad++;
         if (result_vld != '0) begin
            vcnt++;
            vk = k;
            if (result_vld != oh(exp_sel)) vbad++;
         end
         if (k == rst_k) begin
            Rst = 1'b1;
            step();
            chk_reset_state("rst");
            Rst = 1'b0;
            echo = '0;
            exp_sel = 0;
            return;
         end
         case (kind)
            KNone:   e_on = 1'b0;
            KStale:  e_on = (k < (RISE_US + 4) * CLK_MHZ);
            default: e_on = (k >= d * CLK_MHZ) && (k < (d + w) * CLK_MHZ);
         endcase
         for (int j = 0; j < N_SENS; j++) begin
            if (j != exp_sel) begin
               if (pre_next && j == nxt && k >= SLOT_C - 20) echo[j] = 1'b1;
               else echo[j] = (($urandom % 4) == 0);
            end
         end
         echo[exp_sel] = e_on;
         thresh_us = (k >= thr_k) ? 16'(th) : 16'($urandom);
         if (k == drop_k) enable = 1'b0;
         step();
      end
      chk("trig_len", hi, TRIG_C);
      chk("trig_excl", bad, 0);
      chk("vld_cnt", vcnt, 1);
      chk("vld_sel", vbad, 0);
      got = dist_of(exp_sel);
      if (kind == KNorm) begin
         chk($sformatf("dist%0d_w%0d_got%0d_tol", exp_sel, w, got),
             (int'(got) >= w - 1) && (int'(got) <= w + 1), 1);
         chk("tout_ok", timeout[exp_sel], 0);
         chk($sformatf("obst_th%0d_w%0d", th, w), obstacle[exp_sel], (w < th));
      end else begin
         chk($sformatf("dist%0d_to", exp_sel), got, 16'hFFFF);
         chk("tout_set", timeout[exp_sel], 1);
         chk("obst_to", obstacle[exp_sel], 0);
         if (kind != KLong)
            chk($sformatf("rise_to_at%0d", vk),
                (vk >= RISE_US * CLK_MHZ) && (vk <= RISE_US * CLK_MHZ + 3), 1);
      end
      if (enable) begin
         chk("period", trig, oh(nxt));
      end else begin
         chk("idle_trig", trig, 0);
         chk("idle_busy", busy, 0);
      end
      chk("next_sel", cur_sel, nxt);
      exp_sel = nxt;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      kinds[0] = KNorm;  ds[0] = 8; ws[0] = 23;          ths[0] = 20;
      kinds[1] = KNone;  ds[1] = 5; ws[1] = 0;           ths[1] = 10;
      kinds[2] = KStale; ds[2] = 5; ws[2] = 0;           ths[2] = 10;
      kinds[3] = KLong;  ds[3] = 6; ws[3] = ECHO_US + 2; ths[3] = 10;
      for (int i = 4; i < NSLOT; i++) begin
         kinds[i] = (i < 16) ? int'($urandom_range(0, 3)) : KNorm;
         ds[i]    = $urandom_range(TRIG_US + 1, RISE_US - 3);
         ws[i]    = (kinds[i] == KLong) ? ECHO_US + 2 : int'($urandom_range(2, ECHO_US - 3));
         ths[i]   = $urandom_range(0, ECHO_US + 5);
      end
      for (int i = 0; i < NSLOT; i++) begin
         if (ths[i] == ws[i]) ths[i]++;
      end

      Rst = 1'b1;
      step();
      step();
      chk_reset_state("por");
      Rst = 1'b0;
      repeat (10) step();
      chk("idle_busy0", busy, 0);
      chk("idle_trig0", trig, 0);

      enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         run_slot(kinds[i], ds[i], ws[i], ths[i], (kinds[i+1] == KStale), -1, -1);
      end

      // Enable drops while sensor is measuring; slot must still complete.
      run_slot(KNorm, ds[16], ws[16], ths[16], 1'b0, (ds[16] + 1) * CLK_MHZ, -1);
      repeat (20) step();
      chk("stay_idle_busy", busy, 0);
      chk("stay_idle_trig", trig, 0);
      enable = 1'b1;
      run_slot(KNorm, ds[17], ws[17], ths[17], 1'b0, -1, -1);

      run_slot(KNorm, ds[18], ws[18], ths[18], 1'b0, -1, (ds[18] + 3) * CLK_MHZ);
      run_slot(KNorm, ds[19], ws[19], ths[19], 1'b0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
